// File: rtl/alu_ops_pkg.sv
// Shared ALU op codes and issue-controller state encoding, used by the control
// unit, the ALU and the issue controller.
package alu_ops_pkg;

    localparam logic [3:0] OP_HOLD = 4'b0000;
    localparam logic [3:0] OP_ADD  = 4'b0001;
    localparam logic [3:0] OP_SUB  = 4'b0010;
    localparam logic [3:0] OP_MUL  = 4'b0011;
    localparam logic [3:0] OP_DIV  = 4'b0101;
    localparam logic [3:0] OP_AND  = 4'b0110;
    localparam logic [3:0] OP_OR   = 4'b0111;
    localparam logic [3:0] OP_NEG  = 4'b1000;
    localparam logic [3:0] OP_NOT  = 4'b1010;
    localparam logic [3:0] OP_SHL  = 4'b1100;
    localparam logic [3:0] OP_SHR  = 4'b1101;
    localparam logic [3:0] OP_ROL  = 4'b1110;
    localparam logic [3:0] OP_ROR  = 4'b1111;

    typedef logic [2:0] state_t;
    localparam state_t ST_IDLE    = 3'd0;
    localparam state_t ST_ISSUE   = 3'd1;
    localparam state_t ST_ISSUE2  = 3'd2;
    localparam state_t ST_CAPTURE = 3'd3;
    localparam state_t ST_RESP    = 3'd4;

endpackage

// File: rtl/alu_op_decode.sv
// Classifies an ALU select code: legal at all, produces a 64-bit result,
// or needs the select held for two edges.
module alu_op_decode
    import alu_ops_pkg::*;
(
    input  logic [3:0] op,
    output logic       legal,
    output logic       wide,
    output logic       two_cycle
);

    always_comb begin
        legal     = 1'b0;
        wide      = 1'b0;
        two_cycle = 1'b0;
        case (op)
            OP_ADD, OP_SUB, OP_AND, OP_OR, OP_NEG, OP_NOT,
            OP_SHL, OP_SHR, OP_ROL, OP_ROR: legal = 1'b1;
            OP_MUL: begin
                legal = 1'b1;
                wide  = 1'b1;
            end
            OP_DIV: begin
                legal     = 1'b1;
                wide      = 1'b1;
                two_cycle = 1'b1;
            end
            default: legal = 1'b0;
        endcase
    end

endmodule

// File: rtl/alu_issue_ctrl.sv
// Issues one request at a time to the registered ALU, sequences the two-edge
// divide, captures {RHi, RLo} and returns it over a valid/ready response.
module alu_issue_ctrl
    import alu_ops_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic                clk,
    input  logic                clr,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic [3:0]          req_op,
    input  logic [DATA_W-1:0]   req_a,
    input  logic [DATA_W-1:0]   req_b,
    output logic [3:0]          alu_select,
    output logic [DATA_W-1:0]   alu_a,
    output logic [DATA_W-1:0]   alu_y,
    output logic [DATA_W-1:0]   alu_b,
    input  logic [2*DATA_W-1:0] alu_c,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic [DATA_W-1:0]   rsp_lo,
    output logic [DATA_W-1:0]   rsp_hi,
    output logic                rsp_wide,
    output logic                rsp_err,
    output logic                busy
);

    state_t              state_q, state_d;
    logic [3:0]          op_q, op_d;
    logic [DATA_W-1:0]   a_q, a_d, b_q, b_d;
    logic                div_q, div_d, wide_q, wide_d;
    logic [DATA_W-1:0]   rsp_lo_q, rsp_lo_d, rsp_hi_q, rsp_hi_d;
    logic                rsp_wide_q, rsp_wide_d, rsp_err_q, rsp_err_d;
    logic                dec_legal, dec_wide, dec_two;

    alu_op_decode u_dec (
        .op        (req_op),
        .legal     (dec_legal),
        .wide      (dec_wide),
        .two_cycle (dec_two)
    );

    always_comb begin
        state_d    = state_q;
        op_d       = op_q;
        a_d        = a_q;
        b_d        = b_q;
        div_d      = div_q;
        wide_d     = wide_q;
        rsp_lo_d   = rsp_lo_q;
        rsp_hi_d   = rsp_hi_q;
        rsp_wide_d = rsp_wide_q;
        rsp_err_d  = rsp_err_q;
        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    op_d   = req_op;
                    a_d    = req_a;
                    b_d    = req_b;
                    div_d  = dec_two;
                    wide_d = dec_wide;
                    // Rejected requests never reach the ALU; answer directly.
                    if (!dec_legal || (dec_two && req_b == '0)) begin
                        rsp_lo_d   = '0;
                        rsp_hi_d   = '0;
                        rsp_wide_d = 1'b0;
                        rsp_err_d  = 1'b1;
                        state_d    = ST_RESP;
                    end else begin
                        state_d    = ST_ISSUE;
                    end
                end
            end
            ST_ISSUE:   state_d = div_q ? ST_ISSUE2 : ST_CAPTURE;
            ST_ISSUE2:  state_d = ST_CAPTURE;
            ST_CAPTURE: begin
                rsp_lo_d   = alu_c[DATA_W-1:0];
                rsp_hi_d   = wide_q ? alu_c[2*DATA_W-1:DATA_W] : '0;
                rsp_wide_d = wide_q;
                rsp_err_d  = 1'b0;
                state_d    = ST_RESP;
            end
            ST_RESP:    if (rsp_ready) state_d = ST_IDLE;
            default:    state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state_q    <= ST_IDLE;
            op_q       <= OP_HOLD;
            a_q        <= '0;
            b_q        <= '0;
            div_q      <= 1'b0;
            wide_q     <= 1'b0;
            rsp_lo_q   <= '0;
            rsp_hi_q   <= '0;
            rsp_wide_q <= 1'b0;
            rsp_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            op_q       <= op_d;
            a_q        <= a_d;
            b_q        <= b_d;
            div_q      <= div_d;
            wide_q     <= wide_d;
            rsp_lo_q   <= rsp_lo_d;
            rsp_hi_q   <= rsp_hi_d;
            rsp_wide_q <= rsp_wide_d;
            rsp_err_q  <= rsp_err_d;
        end
    end

    // Select decoded from state so an async reset drops it immediately.
    always_comb begin
        case (state_q)
            ST_ISSUE:  alu_select = op_q;
            ST_ISSUE2: alu_select = OP_DIV;
            default:   alu_select = OP_HOLD;
        endcase
    end

    assign req_ready = (state_q == ST_IDLE);
    assign busy      = (state_q != ST_IDLE);
    assign rsp_valid = (state_q == ST_RESP);
    assign alu_a     = a_q;
    assign alu_y     = a_q;
    assign alu_b     = b_q;
    assign rsp_lo    = rsp_lo_q;
    assign rsp_hi    = rsp_hi_q;
    assign rsp_wide  = rsp_wide_q;
    assign rsp_err   = rsp_err_q;

endmodule
